// File: rtl/param_execute.sv
// Execute stage: single-cycle ALU, branch and compare ops, plus logical shifts
// resolved iteratively one bit per cycle, with stall hold, flush and compare flags.
module param_execute #(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 7,
  parameter int IDX_W      = 5,
  parameter int SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              ready_out,
  input  logic [3:0]        control_in,
  input  logic [IDX_W-1:0]  dest_index_in,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic [DATA_W-1:0] npc,
  input  logic [IMM_W-1:0]  immediate,
  input  logic              stall_in,
  input  logic              flush,
  output logic              out_valid,
  output logic [3:0]        control_out,
  output logic [IDX_W-1:0]  dest_index_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] output_reg,
  output logic [DATA_W-1:0] target,
  output logic              branch_taken,
  output logic              DEST_REG_WRITE_EN,
  output logic              ZF,
  output logic              GF,
  output logic              LF
);

  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_SUB    = 4'd1,
    OP_ADD    = 4'd2,
    OP_ADDI   = 4'd3,
    OP_SHLLI  = 4'd4,
    OP_SHRLI  = 4'd5,
    OP_JUMP   = 4'd6,
    OP_JUMPL  = 4'd7,
    OP_JUMPG  = 4'd8,
    OP_JUMPE  = 4'd9,
    OP_JUMPNE = 4'd10,
    OP_CMP    = 4'd11,
    OP_LOAD   = 4'd12,
    OP_LOADI  = 4'd13,
    OP_STORE  = 4'd14,
    OP_MOV    = 4'd15
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic              sh_left_q, sh_left_d;
  logic [IDX_W-1:0]  sh_dest_q, sh_dest_d;
  logic              valid_q, valid_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [IDX_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] oreg_q, oreg_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              taken_q, taken_d;
  logic              zf_q, zf_d, gf_q, gf_d, lf_q, lf_d;

  op_e               op_in;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] acc_shift;
  logic [SH_W-1:0]   shamt;
  logic              hold, accept;
  logic              is_shift_in, is_jump_in, multi_shift, last_shift;
  logic              cmp_eq, cmp_gt, cmp_lt;
  logic              jump_res;

  function automatic logic writes_reg(input logic [3:0] op);
    case (op_e'(op))
      OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI,
      OP_LOAD, OP_LOADI, OP_MOV: writes_reg = 1'b1;
      default:                   writes_reg = 1'b0;
    endcase
  endfunction

  assign op_in       = op_e'(control_in);
  assign imm_sext    = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign shamt       = immediate[SH_W-1:0];
  assign hold        = stall_in && valid_q;
  assign accept      = in_valid && ready_out && !flush;
  assign is_shift_in = (op_in == OP_SHLLI) || (op_in == OP_SHRLI);
  assign is_jump_in  = (op_in >= OP_JUMP) && (op_in <= OP_JUMPNE);
  assign multi_shift = is_shift_in && (shamt != '0);
  assign last_shift  = (cnt_q == SH_W'(1));
  assign acc_shift   = sh_left_q ? (acc_q << 1) : (acc_q >> 1);

  always_comb begin
    cmp_eq = (reg1_data == reg2_data);
    if (SIGNED_CMP != 0) begin
      cmp_gt = $signed(reg1_data) > $signed(reg2_data);
      cmp_lt = $signed(reg1_data) < $signed(reg2_data);
    end else begin
      cmp_gt = reg1_data > reg2_data;
      cmp_lt = reg1_data < reg2_data;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res = '0;
    case (op_in)
      OP_SUB, OP_CMP:            alu_res = reg1_data - reg2_data;
      OP_ADD:                    alu_res = reg1_data + reg2_data;
      OP_ADDI, OP_LOAD, OP_STORE: alu_res = reg1_data + imm_sext;
      OP_SHLLI:                  alu_res = reg1_data << shamt;
      OP_SHRLI:                  alu_res = reg1_data >> shamt;
      OP_MOV:                    alu_res = reg1_data;
      OP_LOADI:                  alu_res = imm_sext;
      default:                   alu_res = '0;
    endcase
  end

  // Conditional jumps resolve against the flags as they stood before this accept.
  always_comb begin
    jump_res = 1'b0;
    case (op_in)
      OP_JUMP:   jump_res = 1'b1;
      OP_JUMPL:  jump_res = lf_q;
      OP_JUMPG:  jump_res = gf_q;
      OP_JUMPE:  jump_res = zf_q;
      OP_JUMPNE: jump_res = !zf_q;
      default:   jump_res = 1'b0;
    endcase
  end

  // FSM state register.
  // NOTE: sequential state is written with non-blocking assignments only, so all flops sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; flush wins over everything else.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (state_q == S_SHIFT) begin
      if (last_shift) state_d = S_IDLE;
    end else if (accept && multi_shift) begin
      state_d = S_SHIFT;
    end
  end

  // FSM outputs.
  always_comb begin
    ready_out         = rst_n && (state_q == S_IDLE) && !hold;
    DEST_REG_WRITE_EN = valid_q && writes_reg(ctrl_q);
  end

  // Datapath next-state: flush > stall hold > shift progress > accept > drain.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sh_left_d = sh_left_q;
    sh_dest_d = sh_dest_q;
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    dest_d    = dest_q;
    result_d  = result_q;
    oreg_d    = oreg_q;
    target_d  = target_q;
    taken_d   = taken_q;
    zf_d      = zf_q;
    gf_d      = gf_q;
    lf_d      = lf_q;
    if (flush) begin
      valid_d = 1'b0;
      taken_d = 1'b0;
    end else if (hold) begin
      valid_d = valid_q;
    end else if (state_q == S_SHIFT) begin
      acc_d = acc_shift;
      cnt_d = cnt_q - SH_W'(1);
      if (last_shift) begin
        valid_d  = 1'b1;
        ctrl_d   = sh_left_q ? OP_SHLLI : OP_SHRLI;
        dest_d   = sh_dest_q;
        result_d = acc_shift;
        oreg_d   = '0;
        target_d = '0;
        taken_d  = 1'b0;
      end
    end else if (accept && multi_shift) begin
      valid_d   = 1'b0;
      acc_d     = reg1_data;
      cnt_d     = shamt;
      sh_left_d = (op_in == OP_SHLLI);
      sh_dest_d = dest_index_in;
    end else if (accept) begin
      valid_d  = 1'b1;
      ctrl_d   = control_in;
      dest_d   = dest_index_in;
      result_d = alu_res;
      oreg_d   = (op_in == OP_STORE) ? reg2_data : '0;
      target_d = is_jump_in ? (npc + imm_sext) : '0;
      taken_d  = jump_res;
      if (op_in == OP_CMP) begin
        zf_d = cmp_eq;
        gf_d = cmp_gt;
        lf_d = cmp_lt;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // NOTE: accumulator and count are reset too, so a reset mid-shift leaves no stale partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sh_left_q <= 1'b0;
      sh_dest_q <= '0;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      dest_q    <= '0;
      result_q  <= '0;
      oreg_q    <= '0;
      target_q  <= '0;
      taken_q   <= 1'b0;
      zf_q      <= 1'b0;
      gf_q      <= 1'b0;
      lf_q      <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sh_left_q <= sh_left_d;
      sh_dest_q <= sh_dest_d;
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      dest_q    <= dest_d;
      result_q  <= result_d;
      oreg_q    <= oreg_d;
      target_q  <= target_d;
      taken_q   <= taken_d;
      zf_q      <= zf_d;
      gf_q      <= gf_d;
      lf_q      <= lf_d;
    end
  end

  assign out_valid      = valid_q;
  assign control_out    = ctrl_q;
  assign dest_index_out = dest_q;
  assign result_out     = result_q;
  assign output_reg     = oreg_q;
  assign target         = target_q;
  assign branch_taken   = taken_q;
  assign ZF             = zf_q;
  assign GF             = gf_q;
  assign LF             = lf_q;

endmodule

// File: tb/tb_param_execute.sv
// Self-checking bench for param_execute: directed scenarios plus randomized
// instructions compared against a transaction-level reference model.
module tb_param_execute;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 7;
  localparam int IDX_W  = 5;

  localparam logic [3:0] NOP = 4'd0, SUB = 4'd1, ADD = 4'd2, ADDI = 4'd3,
                         SHLLI = 4'd4, SHRLI = 4'd5, JUMP = 4'd6, JUMPL = 4'd7,
                         JUMPG = 4'd8, JUMPE = 4'd9, JUMPNE = 4'd10, CMP = 4'd11,
                         LOAD = 4'd12, LOADI = 4'd13, STORE = 4'd14, MOV = 4'd15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, stall_in, flush;
  logic              ready_out;
  logic [3:0]        control_in;
  logic [IDX_W-1:0]  dest_index_in;
  logic [DATA_W-1:0] reg1_data, reg2_data, npc;
  logic [IMM_W-1:0]  immediate;
  logic              out_valid, branch_taken, DEST_REG_WRITE_EN, ZF, GF, LF;
  logic [3:0]        control_out;
  logic [IDX_W-1:0]  dest_index_out;
  logic [DATA_W-1:0] result_out, output_reg, target;

  always #5 clk = ~clk;

  param_execute #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .IDX_W(IDX_W), .SIGNED_CMP(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ready_out(ready_out),
    .control_in(control_in), .dest_index_in(dest_index_in),
    .reg1_data(reg1_data), .reg2_data(reg2_data), .npc(npc),
    .immediate(immediate), .stall_in(stall_in), .flush(flush),
    .out_valid(out_valid), .control_out(control_out),
    .dest_index_out(dest_index_out), .result_out(result_out),
    .output_reg(output_reg), .target(target), .branch_taken(branch_taken),
    .DEST_REG_WRITE_EN(DEST_REG_WRITE_EN), .ZF(ZF), .GF(GF), .LF(LF)
  );

  typedef struct packed {
    logic              valid;
    logic [3:0]        ctrl;
    logic [IDX_W-1:0]  dest;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] oreg;
    logic [DATA_W-1:0] tgt;
    logic              taken;
    logic              we;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t cur;
  logic m_zf, m_gf, m_lf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] imm);
    int v;
    v = int'(imm);
    if (imm[IMM_W-1]) v = v - (1 << IMM_W);
    return DATA_W'(v);
  endfunction

  // Reference model: what one accepted instruction should produce.
  task automatic predict(input logic [3:0] op, input logic [IDX_W-1:0] dest,
                         input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                         input logic [DATA_W-1:0] pc, input logic [IMM_W-1:0] imm);
    int sh;
    sh        = int'(imm) % DATA_W;
    cur.valid = 1'b1;
    cur.ctrl  = op;
    cur.dest  = dest;
    cur.oreg  = (op == STORE) ? r2 : '0;
    cur.tgt   = (op >= JUMP && op <= JUMPNE) ? pc + sext(imm) : '0;
    cur.we    = op inside {SUB, ADD, ADDI, SHLLI, SHRLI, LOAD, LOADI, MOV};
    case (op)
      SUB, CMP:           cur.res = r1 - r2;
      ADD:                cur.res = r1 + r2;
      ADDI, LOAD, STORE:  cur.res = r1 + sext(imm);
      SHLLI:              cur.res = r1 << sh;
      SHRLI:              cur.res = r1 >> sh;
      MOV:                cur.res = r1;
      LOADI:              cur.res = sext(imm);
      default:            cur.res = '0;
    endcase
    case (op)
      JUMP:    cur.taken = 1'b1;
      JUMPL:   cur.taken = m_lf;
      JUMPG:   cur.taken = m_gf;
      JUMPE:   cur.taken = m_zf;
      JUMPNE:  cur.taken = !m_zf;
      default: cur.taken = 1'b0;
    endcase
    if (op == CMP) begin
      m_zf = (r1 == r2);
      m_gf = (r1 > r2);
      m_lf = (r1 < r2);
    end
  endtask

  task automatic check_bundle(input string tag);
    check({tag, "_valid"}, out_valid, cur.valid);
    check({tag, "_ctrl"}, control_out, cur.ctrl);
    check({tag, "_dest"}, dest_index_out, cur.dest);
    check({tag, "_result"}, result_out, cur.res);
    check({tag, "_oreg"}, output_reg, cur.oreg);
    check({tag, "_target"}, target, cur.tgt);
    check({tag, "_taken"}, branch_taken, cur.taken);
    check({tag, "_we"}, DEST_REG_WRITE_EN, cur.we && cur.valid);
    check({tag, "_zf"}, ZF, m_zf);
    check({tag, "_gf"}, GF, m_gf);
    check({tag, "_lf"}, LF, m_lf);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_ctrl"}, control_out, 0);
    check({tag, "_dest"}, dest_index_out, 0);
    check({tag, "_result"}, result_out, 0);
    check({tag, "_oreg"}, output_reg, 0);
    check({tag, "_target"}, target, 0);
    check({tag, "_taken"}, branch_taken, 0);
    check({tag, "_we"}, DEST_REG_WRITE_EN, 0);
    check({tag, "_flags"}, {ZF, GF, LF}, 0);
  endtask

  // Present one instruction and hold it until an accepting edge.
  task automatic drive(input string tag, input logic [3:0] op, input logic [IDX_W-1:0] dest,
                       input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                       input logic [DATA_W-1:0] pc, input logic [IMM_W-1:0] imm);
    int k;
    k = 0;
    while (!ready_out && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_ready"}, ready_out, 1);
    control_in    = op;
    dest_index_in = dest;
    reg1_data     = r1;
    reg2_data     = r2;
    npc           = pc;
    immediate     = imm;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [3:0] op, input logic [IDX_W-1:0] dest,
                      input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                      input logic [DATA_W-1:0] pc, input logic [IMM_W-1:0] imm);
    int sh;
    drive(tag, op, dest, r1, r2, pc, imm);
    predict(op, dest, r1, r2, pc, imm);
    sh = (op == SHLLI || op == SHRLI) ? int'(imm) % DATA_W : 0;
    for (int i = 0; i < sh; i++) begin
      check({tag, "_busy_rdy"}, ready_out, 0);
      check({tag, "_busy_vld"}, out_valid, 0);
      @(posedge clk); #1;
    end
    check_bundle(tag);
  endtask

  // Stall while a result is valid; a competing instruction must be ignored.
  task automatic stall_hold(input string tag, input int n);
    stall_in   = 1'b1;
    in_valid   = 1'b1;
    control_in = ADD;
    reg1_data  = 16'h1234;
    reg2_data  = 16'h4321;
    #1;
    check({tag, "_stall_rdy"}, ready_out, 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_bundle({tag, "_stall"});
      check({tag, "_stall_rdy_hold"}, ready_out, 0);
    end
    stall_in = 1'b0;
    in_valid = 1'b0;
    #1;
    check({tag, "_unstall_rdy"}, ready_out, 1);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    cur.valid = 1'b0;
    check_bundle({tag, "_idle"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a, r_b, r_pc;
    logic [IMM_W-1:0]  r_imm;

    rst_n = 1'b0; in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    control_in = '0; dest_index_in = '0; reg1_data = '0; reg2_data = '0;
    npc = '0; immediate = '0;
    cur = '0; m_zf = 1'b0; m_gf = 1'b0; m_lf = 1'b0;

    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_rdy", ready_out, 1);
    @(posedge clk); #1;

    send("sub", SUB, 5'd2, 16'd10, 16'd3, 16'd0, 7'd0);
    check("sub_res_const", result_out, 16'd7);
    check("sub_we_const", DEST_REG_WRITE_EN, 1);

    send("cmp", CMP, 5'd0, 16'd4, 16'd8, 16'd0, 7'd0);
    check("cmp_flags_const", {ZF, GF, LF}, 3'b001);
    send("jumpl", JUMPL, 5'd0, 16'd0, 16'd0, 16'd0, 7'd1);
    check("jumpl_target_const", target, 16'd1);
    check("jumpl_taken_const", branch_taken, 1);
    send("jumpg", JUMPG, 5'd0, 16'd0, 16'd0, 16'd0, 7'd1);
    check("jumpg_taken_const", branch_taken, 0);

    send("shlli", SHLLI, 5'd3, 16'd8, 16'd0, 16'd0, 7'd3);
    check("shlli_res_const", result_out, 16'd64);
    send("shrli", SHRLI, 5'd3, 16'd8, 16'd0, 16'd0, 7'd1);
    check("shrli_res_const", result_out, 16'd4);
    send("shlli0", SHLLI, 5'd4, 16'h00A5, 16'd0, 16'd0, 7'd16);

    send("add_st", ADD, 5'd1, 16'd10, 16'd5, 16'd0, 7'd0);
    stall_hold("add_st", 3);
    check("add_st_res_const", result_out, 16'd15);
    send("addi", ADDI, 5'd1, 16'd10, 16'd0, 16'd0, 7'd7);
    check("addi_res_const", result_out, 16'd17);

    send("addi_neg", ADDI, 5'd1, 16'd0, 16'd0, 16'd0, 7'h7F);
    check("addi_neg_const", result_out, 16'hFFFF);
    send("add_wrap", ADD, 5'd1, 16'hFFFF, 16'd1, 16'd0, 7'd0);
    check("add_wrap_const", result_out, 16'd0);
    send("store", STORE, 5'd6, 16'd4, 16'd9, 16'd0, 7'd2);
    check("store_res_const", result_out, 16'd6);
    check("store_oreg_const", output_reg, 16'd9);
    check("store_we_const", DEST_REG_WRITE_EN, 0);
    idle_cycle("store");

    // Reset in the middle of a shift.
    send("pre_rst", CMP, 5'd0, 16'd4, 16'd8, 16'd0, 7'd0);
    drive("rst_shift", SHLLI, 5'd7, 16'd3, 16'd0, 16'd0, 7'd5);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_mid_rdy", ready_out, 1);
    cur = '0; m_zf = 1'b0; m_gf = 1'b0; m_lf = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_bundle("rst_after");

    // Flush in the middle of a shift: aborts, flags kept.
    send("pre_fl", CMP, 5'd0, 16'd9, 16'd2, 16'd0, 7'd0);
    drive("fl_shift", SHLLI, 5'd3, 16'd3, 16'd0, 16'd0, 7'd5);
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cur.valid = 1'b0;
    cur.taken = 1'b0;
    check_bundle("fl_shift");
    check("fl_shift_rdy", ready_out, 1);
    repeat (6) @(posedge clk);
    #1;
    check_bundle("fl_shift_late");

    // Flush beats stall and a simultaneous instruction.
    send("pre_fl2", JUMP, 5'd1, 16'd0, 16'd0, 16'h0100, 7'h10);
    stall_in = 1'b1; flush = 1'b1; in_valid = 1'b1;
    control_in = ADD; reg1_data = 16'd1; reg2_data = 16'd1;
    @(posedge clk); #1;
    stall_in = 1'b0; flush = 1'b0; in_valid = 1'b0;
    cur.valid = 1'b0;
    cur.taken = 1'b0;
    check_bundle("fl_prio");

    for (int n = 0; n < 80; n++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_a   = DATA_W'($urandom);
      r_b   = ($urandom_range(0, 3) == 0) ? r_a : DATA_W'($urandom);
      r_pc  = DATA_W'($urandom);
      r_imm = IMM_W'($urandom);
      send($sformatf("rnd%0d", n), r_op, IDX_W'($urandom), r_a, r_b, r_pc, r_imm);
      case ($urandom_range(0, 3))
        0:       stall_hold($sformatf("rnd%0d", n), int'($urandom_range(1, 3)));
        1:       idle_cycle($sformatf("rnd%0d", n));
        default: ;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_execute.md
PARAM_EXECUTE -- requirements
Module: param_execute

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 16, datapath width; must be a power of two, >=8.
- IMM_W, 7, immediate width; sign-extended to DATA_W.
- IDX_W, 5, destination register index width.
- SIGNED_CMP, 0, 1 selects signed CMP comparison, 0 unsigned.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input instruction valid.
- ready_out  out  1  block can accept an instruction this cycle.
- control_in  in  4  opcode: NOP=0, SUB, ADD, ADDI, SHLLI, SHRLI, JUMP, JUMPL, JUMPG, JUMPE, JUMPNE, CMP, LOAD, LOADI, STORE, MOV=15.
- dest_index_in  in  IDX_W  destination register index.
- reg1_data, reg2_data  in  DATA_W  source operands.
- npc  in  DATA_W  next program counter.
- immediate  in  IMM_W  immediate field.
- stall_in  in  1  downstream not ready; hold outputs.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  output bundle valid.
- control_out  out  4  registered opcode.
- dest_index_out  out  IDX_W  registered destination index.
- result_out  out  DATA_W  ALU result or memory address.
- output_reg  out  DATA_W  store data (reg2_data).
- target  out  DATA_W  branch target.
- branch_taken  out  1  resolved jump taken.
- DEST_REG_WRITE_EN  out  1  writeback enable.
- ZF, GF, LF  out  1  registered compare flags.

Function
REQ-003 Accept SHALL occur on a rising edge where in_valid && ready_out && !flush.
REQ-004 ready_out SHALL equal (state==IDLE) && !(stall_in && out_valid).
REQ-005 Single-cycle ops SHALL register all outputs on the accept edge, with out_valid=1 the following cycle.
REQ-006 All arithmetic SHALL wrap modulo 2^DATA_W; sext(imm) denotes immediate sign-extended to DATA_W.
REQ-007 result_out SHALL be:
- SUB: r1-r2
- ADD: r1+r2
- ADDI: r1+sext(imm)
- MOV: r1
- LOADI: sext(imm)
- LOAD/STORE: r1+sext(imm)
- CMP: r1-r2
- jumps and NOP: 0
REQ-008 output_reg SHALL be r2 for STORE and 0 otherwise.
REQ-009 DEST_REG_WRITE_EN SHALL be 1 only when out_valid and the op is SUB, ADD, ADDI, SHLLI, SHRLI, LOAD, LOADI or MOV.
REQ-010 For jumps, target SHALL be npc+sext(imm); otherwise target SHALL be 0.
REQ-011 branch_taken SHALL be:
- JUMP: 1
- JUMPL: LF
- JUMPG: GF
- JUMPE: ZF
- JUMPNE: !ZF
- all other ops: 0
Flag values are those registered before the accept edge.
REQ-012 CMP SHALL update ZF=(r1==r2), GF=(r1>r2), LF=(r1<r2) on its accept edge, using the SIGNED_CMP interpretation; flags SHALL hold otherwise.
REQ-013 Shifts SHALL use shamt=imm[log2(DATA_W)-1:0] and be iterative, 1 bit per cycle:
- FSM states IDLE and SHIFT.
- shamt==0 completes as a single-cycle op.
- shamt>0: accept loads accumulator=r1 and count=shamt, then enters SHIFT.
- Each SHIFT edge shifts by 1 (zero fill) and decrements count.
- The final edge registers outputs and sets out_valid, returning to IDLE.
- Result is visible shamt cycles after the accept edge; out_valid=0 and ready_out=0 while in SHIFT.
REQ-014 When stall_in && out_valid, all outputs, the FSM and the flags SHALL hold.
REQ-015 With no accept and no stall, out_valid SHALL clear on the next edge; other outputs hold.
REQ-016 flush SHALL, on its edge, clear out_valid, DEST_REG_WRITE_EN and branch_taken, abort SHIFT to IDLE, and discard any simultaneous input; flags are preserved.
REQ-017 flush SHALL take priority over stall_in and accept.

Reset
REQ-018 rst_n low SHALL immediately set every output, the flags, the accumulator and the count to 0, and the state to IDLE, including mid-SHIFT.
REQ-019 After rst_n rises, ready_out SHALL be 1.

Verification
REQ-020 SUB r1=10 r2=3 dest=2 -> next cycle: result_out=7, dest_index_out=2, WE=1, out_valid=1.
REQ-021 CMP r1=4 r2=8, then JUMPL npc=0 imm=1 -> LF=1, ZF=0, GF=0; target=1, branch_taken=1. Repeat with JUMPG -> branch_taken=0.
REQ-022 SHLLI r1=8 imm=3 -> ready_out=0 for 3 cycles, then result_out=64 and WE=1. SHRLI r1=8 imm=1 -> result_out=4.
REQ-023 ADD 10+5 with stall_in high for 3 cycles -> result_out=15 held, ready_out=0. Then ADDI r1=10 imm=7 -> result_out=17.
REQ-024 ADDI r1=0 imm=7'h7F -> result_out=16'hFFFF. ADD 16'hFFFF+1 -> result_out=0. STORE r1=4 r2=9 imm=2 -> result_out=6, output_reg=9, WE=0.
REQ-025 SHLLI imm=5 with rst_n low 2 cycles after accept -> all outputs 0, ready_out=1 after release. Same with flush instead of reset -> out_valid=0, flags unchanged.
